fft_hc_ctrl: RTL and testbench

// - MMIO-driven run controller for the FFT accelerator, between the CCI-P MMIO decode and the read/write engines.
// - Latches the DSM base and buffer descriptors (buffer 0 = source, buffer 1 = destination) and sequences one run.
// - Run order: start engines -> wait for both done -> post one completion line to DSM.

---
 rtl/fft_pkg.sv | 85 ++++++++
 rtl/fft_hc_ctrl_if.sv | 25 ++
 rtl/fft_hc_regs.sv | 70 +++++++
 rtl/fft_hc_ctrl.sv | 137 +++++++++++++
 tb/tb_fft_hc_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT host-control block.
//   - HC_* MMIO address map (DWORD addresses) and control codes.
//   - t_hc_address / t_hc_buffer buffer descriptor types.
//   - t_ctrl_state run-controller states and t_hc_dsm_line completion line.
//   - hc_mmio_decode(): maps an MMIO DWORD address to {kind, buffer index}.
package fft_pkg;

  localparam int HC_BUFFER_SIZE = 2;
  localparam int HC_IDX_W       = (HC_BUFFER_SIZE > 1) ? $clog2(HC_BUFFER_SIZE) : 1;

  localparam logic [15:0] HC_MMIO_BASE     = 16'h0040;
  localparam logic [15:0] HC_DSM_BASE_ADDR = 16'h0044;
  localparam logic [15:0] HC_CTRL_ADDR     = 16'h0046;
  localparam logic [15:0] HC_BUF_ADDR_BASE = 16'h0048;

  localparam logic [31:0] HC_CTRL_ASSERT_RST   = 32'd0;
  localparam logic [31:0] HC_CTRL_DEASSERT_RST = 32'd1;
  localparam logic [31:0] HC_CTRL_START        = 32'd3;
  localparam logic [31:0] HC_CTRL_STOP         = 32'd7;

  typedef logic [63:0] t_hc_address;

  typedef struct packed {
    t_hc_address addr;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_START,
    S_WAIT,
    S_DSM,
    S_DONE
  } t_ctrl_state;

  // Completion line: status word in bits [31:0], cycle count above it.
  typedef struct packed {
    logic [447:0] rsvd;
    logic [31:0]  cycles;
    logic [31:0]  status;
  } t_hc_dsm_line;

  typedef enum logic [2:0] {
    HC_K_NONE,
    HC_K_DSM,
    HC_K_CTRL,
    HC_K_BUF_ADDR,
    HC_K_BUF_SIZE
  } t_hc_kind;

  typedef struct packed {
    t_hc_kind              kind;
    logic [HC_IDX_W-1:0]   index;
  } t_hc_decode;

  // Buffer i owns a 4-DWORD slot starting at HC_BUF_ADDR_BASE + 4i:
  // offset 0 is the address, offset 2 the size. Slots beyond the
  // configured buffer count decode as HC_K_NONE.
  function automatic t_hc_decode hc_mmio_decode(input logic [15:0] addr);
    t_hc_decode  r;
    logic [15:0] off;
    logic [31:0] idx;
    r.kind  = HC_K_NONE;
    r.index = '0;
    off     = addr - HC_BUF_ADDR_BASE;
    idx     = {18'd0, off[15:2]};
    if (addr < HC_MMIO_BASE) begin
      r.kind = HC_K_NONE;
    end else if (addr == HC_DSM_BASE_ADDR) begin
      r.kind = HC_K_DSM;
    end else if (addr == HC_CTRL_ADDR) begin
      r.kind = HC_K_CTRL;
    end else if ((addr >= HC_BUF_ADDR_BASE) && (idx < 32'(HC_BUFFER_SIZE))) begin
      r.index = idx[HC_IDX_W-1:0];
      if (off[1:0] == 2'd0) begin
        r.kind = HC_K_BUF_ADDR;
      end else if (off[1:0] == 2'd2) begin
        r.kind = HC_K_BUF_SIZE;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_hc_ctrl_if.sv
// Bus interfaces of the FFT host-control block.
//   fft_hc_mmio_if : MMIO write strobe from the CCI-P decode
//                    (wr_valid, wr_addr DWORD address, wr_data).
//                    master = decoder, slave = controller.
//   fft_hc_dsm_if  : completion-line write toward the DSM
//                    (wr_valid, wr_addr line address, wr_data, wr_ready).
//                    master = controller, slave = write path.
interface fft_hc_mmio_if;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data);
endinterface

interface fft_hc_dsm_if;
  logic         wr_valid;
  logic         wr_ready;
  logic [63:0]  wr_addr;
  logic [511:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
  modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/fft_hc_regs.sv
// fft_hc_regs: buffer descriptor and DSM base register file.
//   clk, rst_n : clock, synchronous active-low reset.
//   wr_en      : MMIO write accepted and descriptor writes currently allowed.
//   wr_dec     : decoded MMIO address {kind, buffer index}.
//   wr_data    : MMIO write data.
//   buf_addr   : per-buffer address; buf_size: per-buffer size (lines).
//   dsm_base   : DSM base byte address.
module fft_hc_regs
  import fft_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  t_hc_decode                          wr_dec,
  input  logic [63:0]                         wr_data,
  output logic [HC_BUFFER_SIZE-1:0][63:0]     buf_addr,
  output logic [HC_BUFFER_SIZE-1:0][31:0]     buf_size,
  output t_hc_address                         dsm_base
);

  t_hc_address dsm_base_q, dsm_base_d;

  genvar gi;
  generate
    for (gi = 0; gi < HC_BUFFER_SIZE; gi++) begin : g_desc
      t_hc_buffer desc_q, desc_d;
      logic       hit;

      always_comb begin
        desc_d = desc_q;
        hit    = wr_en && (wr_dec.index == HC_IDX_W'(gi));
        if (hit && (wr_dec.kind == HC_K_BUF_ADDR)) begin
          desc_d.addr = wr_data;
        end
        if (hit && (wr_dec.kind == HC_K_BUF_SIZE)) begin
          desc_d.size = wr_data[31:0];
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          desc_q <= '0;
        end else begin
          desc_q <= desc_d;
        end
      end

      assign buf_addr[gi] = desc_q.addr;
      assign buf_size[gi] = desc_q.size;
    end
  endgenerate

  always_comb begin
    dsm_base_d = dsm_base_q;
    if (wr_en && (wr_dec.kind == HC_K_DSM)) begin
      dsm_base_d = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dsm_base_q <= '0;
    end else begin
      dsm_base_q <= dsm_base_d;
    end
  end

  assign dsm_base = dsm_base_q;

endmodule

// File: rtl/fft_hc_ctrl.sv
// fft_hc_ctrl: MMIO-driven run controller for the FFT accelerator.
//   clk, rst_n         : clock, synchronous active-low reset.
//   mmio (slave)       : MMIO writes (DSM base, control, buffer descriptors).
//   dsm (master)       : one completion-line write per run.
//   eng_rst_n          : engine reset, low in S_RESET and one cycle after STOP.
//   buf_addr, buf_size : buffer descriptors (0 = source, 1 = destination).
//   rd_start, wr_start : one-cycle engine start pulses.
//   rd_done, wr_done   : sticky engine done flags.
//   busy               : run in progress (S_START, S_WAIT, S_DSM).
module fft_hc_ctrl
  import fft_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  fft_hc_mmio_if.slave                     mmio,
  fft_hc_dsm_if.master                     dsm,
  output logic                             eng_rst_n,
  output logic [HC_BUFFER_SIZE-1:0][63:0]  buf_addr,
  output logic [HC_BUFFER_SIZE-1:0][31:0]  buf_size,
  output logic                             rd_start,
  output logic                             wr_start,
  input  logic                             rd_done,
  input  logic                             wr_done,
  output logic                             busy
);

  t_ctrl_state  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  t_hc_address  dsm_addr_q, dsm_addr_d;
  logic         abort_q, abort_d;

  t_hc_decode   dec;
  t_hc_address  dsm_base;
  logic         accept;
  logic         ctrl_wr;
  logic         is_assert, is_deassert, is_start, is_stop;
  logic         start_go;
  logic         regs_we;
  t_hc_dsm_line line;

  always_comb begin
    dec         = hc_mmio_decode(mmio.wr_addr);
    accept      = mmio.wr_valid && (mmio.wr_addr >= HC_MMIO_BASE);
    ctrl_wr     = accept && (dec.kind == HC_K_CTRL);
    is_assert   = ctrl_wr && (mmio.wr_data[31:0] == HC_CTRL_ASSERT_RST);
    is_deassert = ctrl_wr && (mmio.wr_data[31:0] == HC_CTRL_DEASSERT_RST);
    is_start    = ctrl_wr && (mmio.wr_data[31:0] == HC_CTRL_START);
    is_stop     = ctrl_wr && (mmio.wr_data[31:0] == HC_CTRL_STOP);
    // Descriptors may only change while no run can be using them.
    regs_we     = accept && ((state_q == S_IDLE) || (state_q == S_RESET));
  end

  fft_hc_regs u_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (regs_we),
    .wr_dec   (dec),
    .wr_data  (mmio.wr_data),
    .buf_addr (buf_addr),
    .buf_size (buf_size),
    .dsm_base (dsm_base)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dsm_addr_d = dsm_addr_q;
    abort_d    = 1'b0;
    start_go   = 1'b0;

    case (state_q)
      S_RESET: if (is_deassert) state_d = S_IDLE;
      S_IDLE:  if (is_start) start_go = 1'b1;
      S_DONE:  if (is_start) start_go = 1'b1;
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (rd_done && wr_done) state_d = S_DSM;
      end
      S_DSM:   if (dsm.wr_ready) state_d = S_DONE;
      default: state_d = S_RESET;
    endcase

    // A new run snapshots the DSM line address and clears the counter.
    // An empty source buffer has nothing to stream, so go straight to
    // posting a zero-cycle completion.
    if (start_go) begin
      cnt_d      = '0;
      dsm_addr_d = dsm_base >> 6;
      state_d    = (buf_size[0] == 32'd0) ? S_DSM : S_START;
    end

    // STOP overrides a same-cycle DSM handshake.
    if (is_stop && ((state_q == S_START) || (state_q == S_WAIT) || (state_q == S_DSM))) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end

    // ASSERT_RST has the final word over every other event.
    if (is_assert) begin
      state_d = S_RESET;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RESET;
      cnt_q      <= '0;
      dsm_addr_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dsm_addr_q <= dsm_addr_d;
      abort_q    <= abort_d;
    end
  end

  always_comb begin
    line        = '0;
    line.cycles = 32'(cnt_q);
    line.status = 32'h1;
  end

  // abort_q pulses the engine reset once after a STOP so sticky dones clear.
  assign eng_rst_n    = (state_q != S_RESET) && !abort_q;
  assign rd_start     = (state_q == S_START);
  assign wr_start     = (state_q == S_START);
  assign busy         = (state_q == S_START) || (state_q == S_WAIT) || (state_q == S_DSM);
  assign dsm.wr_valid = (state_q == S_DSM);
  assign dsm.wr_addr  = dsm_addr_q;
  assign dsm.wr_data  = line;

endmodule

// File: tb/tb_fft_hc_ctrl.sv
// Directed testbench for fft_hc_ctrl: reset values, descriptor writes and
// gating, full run with DSM backpressure, STOP abort and restart, ASSERT_RST
// during a pending completion, and the zero-size run.
module tb_fft_hc_ctrl;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic eng_rst_n;
  logic [HC_BUFFER_SIZE-1:0][63:0] buf_addr;
  logic [HC_BUFFER_SIZE-1:0][31:0] buf_size;
  logic rd_start, wr_start, rd_done, wr_done, busy;

  fft_hc_mmio_if mmio_if ();
  fft_hc_dsm_if  dsm_if ();

  fft_hc_ctrl #(.CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mmio      (mmio_if.slave),
    .dsm       (dsm_if.master),
    .eng_rst_n (eng_rst_n),
    .buf_addr  (buf_addr),
    .buf_size  (buf_size),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
    .rd_done   (rd_done),
    .wr_done   (wr_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Event tallies, sampled at each rising edge.
  int rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, vld_cnt = 0;
  always @(posedge clk) begin
    rd_cnt  <= rd_cnt + int'(rd_start);
    wr_cnt  <= wr_cnt + int'(wr_start);
    acc_cnt <= acc_cnt + int'(dsm_if.wr_valid && dsm_if.wr_ready);
    vld_cnt <= vld_cnt + int'(dsm_if.wr_valid);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
      $display("check %-16s got %0h", tag, obs);
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mmio_wr(input logic [15:0] addr, input logic [63:0] data);
    mmio_if.wr_valid = 1'b1;
    mmio_if.wr_addr  = addr;
    mmio_if.wr_data  = data;
    tick(1);
    mmio_if.wr_valid = 1'b0;
    $display("mmio wr addr=%0h data=%0h", addr, data);
  endtask

  int s_rd, s_wr, s_acc, s_vld;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    mmio_if.wr_valid = 1'b0;
    mmio_if.wr_addr  = '0;
    mmio_if.wr_data  = '0;
    dsm_if.wr_ready  = 1'b1;
    rd_done          = 1'b0;
    wr_done          = 1'b0;
    @(posedge clk);
    #1;
    tick(2);

    // Reset state
    check("rst_eng_rst_n", 64'(eng_rst_n), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_start", 64'(rd_start), 64'd0);
    check("rst_dsm_valid", 64'(dsm_if.wr_valid), 64'd0);
    check("rst_buf_addr0", buf_addr[0], 64'd0);
    check("rst_buf_size1", 64'(buf_size[1]), 64'd0);
    check("rst_dsm_addr", dsm_if.wr_addr, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // START while in S_RESET is ignored
    s_rd = rd_cnt;
    mmio_wr(16'h46, 64'd3);
    tick(1);
    check("rst_start_busy", 64'(busy), 64'd0);
    check("rst_start_rd", 64'(rd_cnt - s_rd), 64'd0);

    mmio_wr(16'h46, 64'd1);
    check("deassert_eng", 64'(eng_rst_n), 64'd1);

    // Descriptors
    mmio_wr(16'h48, 64'h1000);
    mmio_wr(16'h4A, 64'd4);
    mmio_wr(16'h4C, 64'h2000);
    mmio_wr(16'h4E, 64'd4);
    mmio_wr(16'h44, 64'h8000);
    check("buf_addr0", buf_addr[0], 64'h1000);
    check("buf_size0", 64'(buf_size[0]), 64'd4);
    check("buf_addr1", buf_addr[1], 64'h2000);
    check("buf_size1", 64'(buf_size[1]), 64'd4);

    // Buffer index 2 does not exist
    mmio_wr(16'h50, 64'hDEAD);
    mmio_wr(16'h52, 64'd9);
    check("idx2_addr0", buf_addr[0], 64'h1000);
    check("idx2_addr1", buf_addr[1], 64'h2000);
    check("idx2_size0", 64'(buf_size[0]), 64'd4);
    check("idx2_size1", 64'(buf_size[1]), 64'd4);

    // Run 1: done 10 cycles after rd_start, DSM ready held low 5 cycles
    dsm_if.wr_ready = 1'b0;
    s_rd = rd_cnt; s_wr = wr_cnt; s_acc = acc_cnt;
    mmio_wr(16'h46, 64'd3);
    check("r1_rd_start", 64'(rd_start), 64'd1);
    check("r1_wr_start", 64'(wr_start), 64'd1);
    check("r1_busy", 64'(busy), 64'd1);
    tick(1);
    check("r1_rd_pulse_end", 64'(rd_start), 64'd0);
    tick(9);
    rd_done = 1'b1;
    wr_done = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      check("r1_valid", 64'(dsm_if.wr_valid), 64'd1);
      check("r1_data", dsm_if.wr_data[63:0], {32'd10, 32'h1});
      check("r1_addr", dsm_if.wr_addr, 64'h200);
      tick(1);
    end
    check("r1_valid_hold", 64'(dsm_if.wr_valid), 64'd1);
    check("r1_data_hi", 64'(|dsm_if.wr_data[511:64]), 64'd0);
    dsm_if.wr_ready = 1'b1;
    tick(1);
    check("r1_valid_done", 64'(dsm_if.wr_valid), 64'd0);
    check("r1_busy_done", 64'(busy), 64'd0);
    tick(2);
    check("r1_accepts", 64'(acc_cnt - s_acc), 64'd1);
    check("r1_rd_pulses", 64'(rd_cnt - s_rd), 64'd1);
    check("r1_wr_pulses", 64'(wr_cnt - s_wr), 64'd1);
    rd_done = 1'b0;
    wr_done = 1'b0;

    // Run 2: descriptor write while busy dropped, then STOP in S_WAIT
    s_rd = rd_cnt; s_vld = vld_cnt;
    mmio_wr(16'h46, 64'd3);
    tick(1);
    mmio_wr(16'h48, 64'h5555);
    check("busy_wr_addr0", buf_addr[0], 64'h1000);
    tick(3);
    mmio_wr(16'h46, 64'd7);
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_eng_low", 64'(eng_rst_n), 64'd0);
    tick(1);
    check("stop_eng_high", 64'(eng_rst_n), 64'd1);
    tick(2);
    check("stop_no_dsm", 64'(vld_cnt - s_vld), 64'd0);
    check("stop_rd_pulses", 64'(rd_cnt - s_rd), 64'd1);

    // Run 3: restart after STOP, counter must restart from zero
    mmio_wr(16'h46, 64'd3);
    check("r3_rd_start", 64'(rd_start), 64'd1);
    tick(3);
    rd_done = 1'b1;
    wr_done = 1'b1;
    tick(1);
    check("r3_valid", 64'(dsm_if.wr_valid), 64'd1);
    check("r3_data", dsm_if.wr_data[63:0], {32'd3, 32'h1});
    tick(1);
    check("r3_valid_done", 64'(dsm_if.wr_valid), 64'd0);
    rd_done = 1'b0;
    wr_done = 1'b0;

    // Run 4: ASSERT_RST while completion is pending
    dsm_if.wr_ready = 1'b0;
    s_acc = acc_cnt;
    mmio_wr(16'h46, 64'd3);
    tick(2);
    rd_done = 1'b1;
    wr_done = 1'b1;
    tick(1);
    check("r4_valid", 64'(dsm_if.wr_valid), 64'd1);
    check("r4_data", dsm_if.wr_data[63:0], {32'd2, 32'h1});
    tick(1);
    mmio_wr(16'h46, 64'd0);
    check("r4_valid_drop", 64'(dsm_if.wr_valid), 64'd0);
    check("r4_eng_rst", 64'(eng_rst_n), 64'd0);
    check("r4_busy", 64'(busy), 64'd0);
    check("r4_no_accept", 64'(acc_cnt - s_acc), 64'd0);
    rd_done = 1'b0;
    wr_done = 1'b0;
    dsm_if.wr_ready = 1'b1;

    // Zero-size run
    mmio_wr(16'h4A, 64'd0);
    check("zero_size0", 64'(buf_size[0]), 64'd0);
    mmio_wr(16'h46, 64'd1);
    s_rd = rd_cnt; s_wr = wr_cnt;
    mmio_wr(16'h46, 64'd3);
    check("zero_rd_start", 64'(rd_start), 64'd0);
    check("zero_valid", 64'(dsm_if.wr_valid), 64'd1);
    check("zero_data", dsm_if.wr_data[63:0], {32'd0, 32'h1});
    check("zero_addr", dsm_if.wr_addr, 64'h200);
    tick(1);
    check("zero_valid_done", 64'(dsm_if.wr_valid), 64'd0);
    tick(1);
    check("zero_rd_pulses", 64'(rd_cnt - s_rd), 64'd0);
    check("zero_wr_pulses", 64'(wr_cnt - s_wr), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
